blink_pattern_gen: RTL and testbench
====================================

// Module: blink_pattern_gen
// PURPOSE
//   Timing source for the low_freq_blink LED path: divides the system clock into slow ticks
//   and drives a programmable on/off square wave into the downstream LED-driving stage
//   (its inSignal input) via blink_out.
//   Provides tick and period-done strobes for other logic and for bench observation.
// PARAMETERS
//   PRESCALE  12000000  clk cycles per tick; legal >= 1 (synthesis: 1 tick/s at 12 MHz)
//   CNT_W     8         width of on_ticks/off_ticks and internal phase counter
// PORTS
//   clk          input   1      system clock, all state on rising edge
//   rst          input   1      asynchronous, active-high reset
//   enable       input   1      1 = run pattern, 0 = force idle (LED off)
//   on_ticks     input   CNT_W  ON-phase length in ticks (0 treated as 1)
//   off_ticks    input   CNT_W  OFF-phase length in ticks (0 treated as 1)
//   blink_out    output  1      registered LED drive, feeds downstream inSignal
//   tick_out     output  1      1-cycle strobe on last cycle of each prescaler period
//   period_done  output  1      registered 1-cycle strobe, first cycle of each new ON phase
// BEHAVIOUR
//   Reset: async on rst=1, no clock needed: state=IDLE, pre_cnt=0, phase_cnt=0,
//     on_len=1, off_len=1, blink_out=0, period_done=0, tick_out=0. Reset wins over all inputs.
//   Prescaler pre_cnt: width max(1,$clog2(PRESCALE)); counts 0..PRESCALE-1 then wraps to 0;
//     held at 0 in IDLE. tick_out = (state!=IDLE) && (pre_cnt==PRESCALE-1), decoded from
//     registers only (no input-to-output comb path). PRESCALE=1 -> tick_out high every non-IDLE cycle.
//   FSM states IDLE, ON, OFF:
//     IDLE: blink_out=0. enable=1 at edge -> ON; latch on_len/off_len from inputs (0 -> 1),
//       pre_cnt=0, phase_cnt=0. Latency enable-sampled -> blink_out=1: 1 cycle.
//     ON: blink_out=1. On tick: if phase_cnt==on_len-1 -> OFF, phase_cnt=0; else phase_cnt+1.
//     OFF: blink_out=0. On tick: if phase_cnt==off_len-1 -> ON, phase_cnt=0, re-latch
//       on_len/off_len, period_done=1 for that one following cycle; else phase_cnt+1.
//     Any state, enable=0 at edge -> IDLE next edge; blink_out=0, counters cleared. Takes
//       priority over a coincident tick/phase transition; no period_done on that edge.
//   Timing: ON lasts exactly on_len*PRESCALE cycles, OFF exactly off_len*PRESCALE cycles.
//   on_ticks/off_ticks are sampled only at phase-length latch points (enter from IDLE, OFF->ON);
//     mid-period changes take effect at the next period.
//   phase_cnt compares against latched lengths only; no overflow possible (max 2^CNT_W-1).
//   Re-enable after IDLE always restarts with a full ON phase.
// TESTING  (bench uses PRESCALE=4, CNT_W=8 unless stated)
//   1 on=2, off=3, enable=1 sampled at edge E -> blink_out 1 from E+1 for 8 cycles, 0 for 12,
//     period 20 cycles; period_done pulses 1 cycle at E+21; tick_out every 4 cycles.
//   2 on=0, off=0 -> treated as 1: blink_out 4 cycles high / 4 low, period_done every 8 cycles.
//   3 enable dropped 3 cycles into ON -> blink_out 0 next edge, tick_out stops; re-enable ->
//     full 8-cycle ON phase (on=2) restarts, no period_done until first full OFF completes.
//   4 on=2/off=3 running; change to on=1/off=1 mid-ON -> current period stays 8/12, next
//     period 4/4; change visible only after period_done.
//   5 rst pulsed asynchronously (between edges) mid-OFF -> blink_out, tick_out, period_done
//     0 immediately; after release with enable=1, ON resumes 1 cycle after first sampling edge.
//   6 PRESCALE=1, on=1, off=2 -> tick_out constant 1 while running, blink_out pattern 1,0,0
//     repeating, period_done every 3 cycles.

Source files
------------

// File: rtl/blink_pattern_gen_if.sv
// Bundle of the blink generator's control inputs and its LED/strobe outputs.
//   enable      : 1 = run the on/off pattern, 0 = force idle (LED off)
//   on_ticks    : ON-phase length in ticks (0 treated as 1)
//   off_ticks   : OFF-phase length in ticks (0 treated as 1)
//   blink_out   : registered LED drive for the downstream LED stage
//   tick_out    : 1-cycle strobe on the last cycle of each prescaler period
//   period_done : 1-cycle strobe on the first cycle of each new ON phase
// Modports: master drives the controls, slave (the generator) drives the outputs.
interface blink_pattern_gen_if #(
  parameter int unsigned CNT_W = 8
);
  logic             enable;
  logic [CNT_W-1:0] on_ticks;
  logic [CNT_W-1:0] off_ticks;
  logic             blink_out;
  logic             tick_out;
  logic             period_done;

  modport master (
    output enable,
    output on_ticks,
    output off_ticks,
    input  blink_out,
    input  tick_out,
    input  period_done
  );

  modport slave (
    input  enable,
    input  on_ticks,
    input  off_ticks,
    output blink_out,
    output tick_out,
    output period_done
  );
endinterface

// File: rtl/blink_pattern_gen.sv
// Slow-tick on/off square-wave generator for the low-frequency LED blink path.
// A prescaler divides clk into ticks; a three-state FSM (idle/on/off) counts ticks
// against phase lengths latched at the start of every period and drives blink_out.
// Ports:
//   clk : system clock, all state on the rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of blink_pattern_gen_if (enable, on_ticks, off_ticks in;
//         blink_out, tick_out, period_done out)
module blink_pattern_gen #(
  parameter int unsigned PRESCALE = 12000000,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  blink_pattern_gen_if.slave  bus
);

  localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    StIdle,
    StOn,
    StOff
  } state_t;

  state_t           state_q;
  logic [PreW-1:0]  pre_cnt_q;
  logic [CNT_W-1:0] phase_cnt_q;
  logic [CNT_W-1:0] on_len_q;
  logic [CNT_W-1:0] off_len_q;
  logic             blink_q;
  logic             period_done_q;

  logic             tick;
  logic [PreW-1:0]  pre_cnt_next;

  // A zero-length phase would never end; treat it as one tick.
  function automatic logic [CNT_W-1:0] fix_len(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  // Decoded from registers only, so no input reaches tick_out combinationally.
  always_comb begin
    tick         = (state_q != StIdle) && (pre_cnt_q == PreMax);
    pre_cnt_next = (pre_cnt_q == PreMax) ? '0 : pre_cnt_q + PreW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      pre_cnt_q     <= '0;
      phase_cnt_q   <= '0;
      on_len_q      <= CNT_W'(1);
      off_len_q     <= CNT_W'(1);
      blink_q       <= 1'b0;
      period_done_q <= 1'b0;
    end else if (!bus.enable) begin
      // Disable beats any coincident tick or phase change.
      state_q       <= StIdle;
      pre_cnt_q     <= '0;
      phase_cnt_q   <= '0;
      blink_q       <= 1'b0;
      period_done_q <= 1'b0;
    end else begin
      period_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          state_q     <= StOn;
          on_len_q    <= fix_len(bus.on_ticks);
          off_len_q   <= fix_len(bus.off_ticks);
          pre_cnt_q   <= '0;
          phase_cnt_q <= '0;
          blink_q     <= 1'b1;
        end
        StOn: begin
          pre_cnt_q <= pre_cnt_next;
          if (tick) begin
            if (phase_cnt_q == on_len_q - CNT_W'(1)) begin
              state_q     <= StOff;
              phase_cnt_q <= '0;
              blink_q     <= 1'b0;
            end else begin
              phase_cnt_q <= phase_cnt_q + CNT_W'(1);
            end
          end
        end
        StOff: begin
          pre_cnt_q <= pre_cnt_next;
          if (tick) begin
            if (phase_cnt_q == off_len_q - CNT_W'(1)) begin
              // New period: lengths are only ever picked up here or on leaving idle.
              state_q       <= StOn;
              phase_cnt_q   <= '0;
              on_len_q      <= fix_len(bus.on_ticks);
              off_len_q     <= fix_len(bus.off_ticks);
              blink_q       <= 1'b1;
              period_done_q <= 1'b1;
            end else begin
              phase_cnt_q <= phase_cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_q     <= StIdle;
          pre_cnt_q   <= '0;
          phase_cnt_q <= '0;
          blink_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.blink_out   = blink_q;
  assign bus.tick_out    = tick;
  assign bus.period_done = period_done_q;

`ifndef SYNTHESIS
  // A new period always starts with the LED lit.
  a_done_lit : assert property (@(posedge clk) disable iff (rst)
    bus.period_done |-> bus.blink_out);
  // The LED tracks the ON state exactly.
  a_blink_on : assert property (@(posedge clk) disable iff (rst)
    bus.blink_out == (state_q == StOn));
`endif

endmodule

// File: tb/tb_blink_pattern_gen.sv
module tb_blink_pattern_gen;

  localparam int unsigned CntW = 8;
  localparam int unsigned P0   = 4;
  localparam int unsigned P1   = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            en    [2];
  logic [CntW-1:0] on_t  [2];
  logic [CntW-1:0] off_t [2];

  blink_pattern_gen_if #(.CNT_W(CntW)) bus4 ();
  blink_pattern_gen_if #(.CNT_W(CntW)) bus1 ();

  assign bus4.enable    = en[0];
  assign bus4.on_ticks  = on_t[0];
  assign bus4.off_ticks = off_t[0];
  assign bus1.enable    = en[1];
  assign bus1.on_ticks  = on_t[1];
  assign bus1.off_ticks = off_t[1];

  blink_pattern_gen #(.PRESCALE(P0), .CNT_W(CntW)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  blink_pattern_gen #(.PRESCALE(P1), .CNT_W(CntW)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0b expected=%0b", name, $time, act, exp);
    end
  endtask

  // Reference model: a running pattern is just the cycle count t since the
  // period began; ON covers the first on*P cycles, the period is (on+off)*P.
  bit running [2] = '{1'b0, 1'b0};
  int t       [2] = '{0, 0};
  int onl     [2] = '{1, 1};
  int offl    [2] = '{1, 1};
  bit pd_m    [2] = '{1'b0, 1'b0};

  function automatic int pval(input int i);
    return (i == 0) ? int'(P0) : int'(P1);
  endfunction

  function automatic int fixlen(input logic [CntW-1:0] v);
    return (v == 0) ? 1 : int'(v);
  endfunction

  function automatic logic exp_blink(input int i);
    return running[i] && (t[i] < onl[i] * pval(i));
  endfunction

  function automatic logic exp_tick(input int i);
    return running[i] && ((t[i] % pval(i)) == pval(i) - 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      pd_m[i] = 1'b0;
      if (rst) begin
        running[i] = 1'b0;
        t[i]       = 0;
      end else if (!en[i]) begin
        running[i] = 1'b0;
      end else if (!running[i]) begin
        running[i] = 1'b1;
        t[i]       = 0;
        onl[i]     = fixlen(on_t[i]);
        offl[i]    = fixlen(off_t[i]);
      end else begin
        t[i]++;
        if (t[i] == (onl[i] + offl[i]) * pval(i)) begin
          t[i]    = 0;
          onl[i]  = fixlen(on_t[i]);
          offl[i] = fixlen(off_t[i]);
          pd_m[i] = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("blink_p4", bus4.blink_out, exp_blink(0));
    check("tick_p4", bus4.tick_out, exp_tick(0));
    check("done_p4", bus4.period_done, pd_m[0]);
    check("blink_p1", bus1.blink_out, exp_blink(1));
    check("tick_p1", bus1.tick_out, exp_tick(1));
    check("done_p1", bus1.period_done, pd_m[1]);
  end

  // Captured outputs, index k = k-th clock edge after the inputs were set.
  logic cb4 [64];
  logic ct4 [64];
  logic cp4 [64];
  logic cb1 [64];
  logic ct1 [64];
  logic cp1 [64];

  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
      cb4[k] = bus4.blink_out;
      ct4[k] = bus4.tick_out;
      cp4[k] = bus4.period_done;
      cb1[k] = bus1.blink_out;
      ct1[k] = bus1.tick_out;
      cp1[k] = bus1.period_done;
    end
  endtask

  task automatic restart4(input logic [CntW-1:0] on_v, input logic [CntW-1:0] off_v);
    @(negedge clk);
    en[0] = 1'b0;
    @(negedge clk);
    on_t[0]  = on_v;
    off_t[0] = off_v;
    en[0]    = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      en[i]    = 1'b0;
      on_t[i]  = '0;
      off_t[i] = '0;
    end
    #2;
    check("rst_blink", bus4.blink_out, 1'b0);
    check("rst_tick", bus4.tick_out, 1'b0);
    check("rst_done", bus4.period_done, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // on=2/off=3 at P=4 alongside on=1/off=2 at P=1.
    @(negedge clk);
    on_t[0] = 8'd2; off_t[0] = 8'd3; en[0] = 1'b1;
    on_t[1] = 8'd1; off_t[1] = 8'd2; en[1] = 1'b1;
    capture(30);
    check("s1_on_first", cb4[0], 1'b1);
    check("s1_on_last", cb4[7], 1'b1);
    check("s1_off_first", cb4[8], 1'b0);
    check("s1_off_last", cb4[19], 1'b0);
    check("s1_reon", cb4[20], 1'b1);
    check("s1_done_early", cp4[19], 1'b0);
    check("s1_done", cp4[20], 1'b1);
    check("s1_tick_idle", ct4[2], 1'b0);
    check("s1_tick", ct4[3], 1'b1);
    check("s6_b0", cb1[0], 1'b1);
    check("s6_b1", cb1[1], 1'b0);
    check("s6_b2", cb1[2], 1'b0);
    check("s6_b3", cb1[3], 1'b1);
    check("s6_tick", ct1[4], 1'b1);
    check("s6_done3", cp1[3], 1'b1);
    check("s6_done4", cp1[4], 1'b0);
    check("s6_done6", cp1[6], 1'b1);

    // Zero lengths act as one tick.
    restart4(8'd0, 8'd0);
    capture(12);
    check("s2_on_last", cb4[3], 1'b1);
    check("s2_off", cb4[4], 1'b0);
    check("s2_off_last", cb4[7], 1'b0);
    check("s2_reon", cb4[8], 1'b1);
    check("s2_done", cp4[8], 1'b1);

    // Drop enable three cycles into ON, then re-enable.
    restart4(8'd2, 8'd3);
    capture(3);
    @(negedge clk);
    en[0] = 1'b0;
    capture(1);
    check("s3_drop_blink", cb4[0], 1'b0);
    check("s3_drop_tick", ct4[0], 1'b0);
    @(negedge clk);
    en[0] = 1'b1;
    capture(24);
    check("s3_full_on", cb4[7], 1'b1);
    check("s3_off", cb4[8], 1'b0);
    check("s3_no_done", cp4[8], 1'b0);
    check("s3_done", cp4[20], 1'b1);

    // Change lengths mid-ON; takes effect at the next period.
    restart4(8'd2, 8'd3);
    capture(2);
    @(negedge clk);
    on_t[0] = 8'd1; off_t[0] = 8'd1;
    capture(30);
    check("s4_on_kept", cb4[5], 1'b1);
    check("s4_off", cb4[6], 1'b0);
    check("s4_off_kept", cb4[17], 1'b0);
    check("s4_done", cp4[18], 1'b1);
    check("s4_new_on", cb4[21], 1'b1);
    check("s4_new_off", cb4[22], 1'b0);
    check("s4_new_off_last", cb4[25], 1'b0);
    check("s4_done2", cp4[26], 1'b1);

    // Asynchronous reset between edges while in OFF.
    restart4(8'd2, 8'd3);
    capture(12);
    #1;
    rst = 1'b1;
    #1;
    check("s5_blink", bus4.blink_out, 1'b0);
    check("s5_tick", bus4.tick_out, 1'b0);
    check("s5_done", bus4.period_done, 1'b0);
    check("s5_blink_p1", bus1.blink_out, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    capture(1);
    check("s5_resume", cb4[0], 1'b1);

    // Randomised run against the model.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 39) == 0) en[i] = ~en[i];
        if ($urandom_range(0, 9) == 0) on_t[i] = CntW'($urandom_range(0, 4));
        if ($urandom_range(0, 9) == 0) off_t[i] = CntW'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 499) == 0) begin
        #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
